// File: rtl/pio_gen2_if.sv
// Register-bus bundle for the PIO block: address/strobe/data from the host, read data back.
interface pio_gen2_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_gen2.sv
// Parallel I/O port: data/direction registers, synchronized inputs with sticky
// edge capture and a masked interrupt.
module pio_gen2 #(
  parameter int unsigned DATA_WIDTH  = 12,
  parameter int unsigned RESET_VALUE = 0,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pio_gen2_if.slave             bus,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] out_en,
  output logic                  irq
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam logic [DW-1:0] RST_DATA = DW'(RESET_VALUE);

  localparam logic [2:0] A_DATA    = 3'd0;
  localparam logic [2:0] A_DIR     = 3'd1;
  localparam logic [2:0] A_IRQMASK = 3'd2;
  localparam logic [2:0] A_EDGECAP = 3'd3;
  localparam logic [2:0] A_OUTSET  = 3'd4;
  localparam logic [2:0] A_OUTCLR  = 3'd5;

  logic [DW-1:0] r_data_out;
  logic [DW-1:0] r_dir;
  logic [DW-1:0] r_irqmask;
  logic [DW-1:0] r_edgecap;
  logic [DW-1:0] r_s1;
  logic [DW-1:0] r_s2;
  logic [DW-1:0] r_s3;
  logic [1:0]    r_warm;

  logic          w_wr;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_clr;
  logic [DW-1:0] w_edge;
  logic [DW-1:0] w_cap;
  logic          w_armed;

  assign w_wr    = bus.chipselect & ~bus.write_n;
  assign w_wdata = bus.writedata[DW-1:0];

  if (DW < 32) begin : g_pad
    logic w_unused_wdata;
    assign w_unused_wdata = ^bus.writedata[31:DW];
  end

  // Host-writable control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= RST_DATA;
      r_dir      <= '0;
      r_irqmask  <= '0;
    end else if (w_wr) begin
      case (bus.address)
        A_DATA:    r_data_out <= w_wdata;
        A_DIR:     r_dir      <= w_wdata;
        A_IRQMASK: r_irqmask  <= w_wdata;
        A_OUTSET:  r_data_out <= r_data_out | w_wdata;
        A_OUTCLR:  r_data_out <= r_data_out & ~w_wdata;
        default:   ;
      endcase
    end
  end

  // Input synchronizer plus one delay stage for edge comparison
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= in_port;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Warm-up counter masks the pipeline filling with pins already high at reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_warm <= 2'd0;
    end else if (r_warm != 2'd3) begin
      r_warm <= r_warm + 2'd1;
    end
  end

  assign w_armed = (r_warm == 2'd3);

  always_comb begin
    w_edge = '0;
    case (EDGE_TYPE)
      0:       w_edge = r_s2 & ~r_s3;
      1:       w_edge = ~r_s2 & r_s3;
      default: w_edge = r_s2 ^ r_s3;
    endcase
  end

  assign w_cap = w_edge & ~r_dir & {DW{w_armed}};
  assign w_clr = (w_wr && (bus.address == A_EDGECAP)) ? w_wdata : '0;

  // Sticky capture; a new edge overrides a simultaneous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edgecap <= '0;
    end else begin
      r_edgecap <= (r_edgecap & ~w_clr) | w_cap;
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      A_DATA:    bus.readdata = 32'((r_data_out & r_dir) | (r_s2 & ~r_dir));
      A_DIR:     bus.readdata = 32'(r_dir);
      A_IRQMASK: bus.readdata = 32'(r_irqmask);
      A_EDGECAP: bus.readdata = 32'(r_edgecap);
      default:   bus.readdata = '0;
    endcase
  end

  assign out_port = r_data_out;
  assign out_en   = r_dir;
  assign irq      = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_pio_gen2.sv
// Directed bench for pio_gen2: rising-edge instance with non-zero reset value,
// plus an any-edge instance with pins held high through reset.
module tb_pio_gen2;

  logic        clk;
  logic        reset_n;
  logic [11:0] in_port0;
  logic [11:0] out_port0;
  logic [11:0] out_en0;
  logic        irq0;
  logic [11:0] in_port2;
  logic [11:0] out_port2;
  logic [11:0] out_en2;
  logic        irq2;
  logic [31:0] d;

  int n_checks;
  int n_fail;

  pio_gen2_if bus0 ();
  pio_gen2_if bus2 ();

  pio_gen2 #(.DATA_WIDTH(12), .RESET_VALUE(32'h5A3), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave),
    .in_port(in_port0), .out_port(out_port0), .out_en(out_en0), .irq(irq0)
  );

  pio_gen2 #(.DATA_WIDTH(12), .RESET_VALUE(0), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2.slave),
    .in_port(in_port2), .out_port(out_port2), .out_en(out_en2), .irq(irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge
  task automatic wr0(input logic [2:0] a, input logic [31:0] wd);
    bus0.address    = a;
    bus0.writedata  = wd;
    bus0.chipselect = 1'b1;
    bus0.write_n    = 1'b0;
    @(negedge clk);
    bus0.chipselect = 1'b0;
    bus0.write_n    = 1'b1;
  endtask

  task automatic rd0(input logic [2:0] a, output logic [31:0] rd);
    bus0.address = a;
    #1;
    rd = bus0.readdata;
  endtask

  task automatic rd2(input logic [2:0] a, output logic [31:0] rd);
    bus2.address = a;
    #1;
    rd = bus2.readdata;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b1;
    bus0.address = 3'd0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = '0;
    bus2.address = 3'd0; bus2.chipselect = 1'b0; bus2.write_n = 1'b1; bus2.writedata = '0;
    in_port0 = 12'h000;
    in_port2 = 12'hFFF;

    #2 reset_n = 1'b0;
    #1;
    check("rst_out_port", 32'(out_port0), 32'h5A3);
    check("rst_out_en",   32'(out_en0),   32'h0);
    check("rst_irq",      32'(irq0),      32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Any-edge instance: pins high through reset release must not capture
    repeat (10) @(negedge clk);
    rd2(3'd3, d); check("warm_edgecap", d, 32'h0);
    check("warm_irq", 32'(irq2), 32'h0);
    rd2(3'd0, d); check("dut2_data_in", d, 32'hFFF);
    in_port2 = 12'hFFE;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rd2(3'd3, d); check("any_fall_cap", d, 32'h001);

    // Register access and set/clear aliases
    @(negedge clk);
    wr0(3'd1, 32'hFFF);
    wr0(3'd0, 32'hA5A);
    wr0(3'd4, 32'h005);
    wr0(3'd5, 32'h008);
    check("reg_out_port", 32'(out_port0), 32'hA57);
    check("reg_out_en",   32'(out_en0),   32'hFFF);
    rd0(3'd0, d); check("reg_data_rd", d, 32'h0000_0A57);
    rd0(3'd4, d); check("outset_rd0", d, 32'h0);
    rd0(3'd5, d); check("outclr_rd0", d, 32'h0);

    // Rising edge latency and interrupt clear
    wr0(3'd1, 32'h000);
    wr0(3'd2, 32'h001);
    rd0(3'd2, d); check("irqmask_rd", d, 32'h001);
    in_port0 = 12'h001;
    @(posedge clk);
    @(negedge clk);
    rd0(3'd3, d); check("rise_n0", d, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rd0(3'd3, d); check("rise_n1", d, 32'h0);
    check("rise_irq_n1", 32'(irq0), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rd0(3'd3, d); check("rise_n2", d, 32'h001);
    check("rise_irq_n2", 32'(irq0), 32'h1);
    wr0(3'd3, 32'h001);
    check("irq_cleared", 32'(irq0), 32'h0);
    rd0(3'd0, d); check("data_in_rd", d, 32'h001);

    // Edge capture and write-1-to-clear collide on bit 3
    in_port0 = 12'h009;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    wr0(3'd3, 32'h008);
    rd0(3'd3, d); check("set_wins", d, 32'h008);
    wr0(3'd3, 32'h008);
    rd0(3'd3, d); check("w1c_clear", d, 32'h0);
    in_port0 = 12'h001;
    repeat (4) @(negedge clk);
    rd0(3'd3, d); check("fall_ignored", d, 32'h0);

    // Mixed direction readback and output-bit masking
    wr0(3'd1, 32'h0F0);
    wr0(3'd0, 32'h0FF);
    check("mix_out_port", 32'(out_port0), 32'h0FF);
    check("mix_out_en",   32'(out_en0),   32'h0F0);
    in_port0 = 12'hF0F;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rd0(3'd0, d); check("mix_data_rd", d, 32'hFFF);
    rd0(3'd3, d); check("mix_edgecap", d, 32'hF0E);
    check("mix_irq", 32'(irq0), 32'h0);
    wr0(3'd1, 32'h0F2);
    rd0(3'd3, d); check("dir_flip_keeps", d, 32'hF0E);
    wr0(3'd3, 32'hFFF);
    rd0(3'd3, d); check("clear_all", d, 32'h0);
    in_port0 = 12'hF2F;
    repeat (4) @(negedge clk);
    rd0(3'd3, d); check("out_bit_no_cap", d, 32'h0);
    wr0(3'd6, 32'hFFF);
    check("addr6_wr_ignored", 32'(out_port0), 32'h0FF);
    rd0(3'd1, d); check("addr6_dir_kept", d, 32'h0F2);
    rd0(3'd7, d); check("addr7_rd0", d, 32'h0);

    // Reset mid-operation with irq asserted
    wr0(3'd1, 32'h000);
    wr0(3'd2, 32'h00C);
    in_port0 = 12'h000;
    repeat (4) @(negedge clk);
    wr0(3'd3, 32'hFFF);
    in_port0 = 12'h00C;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rd0(3'd3, d); check("pre_rst_edgecap", d, 32'h00C);
    check("pre_rst_irq", 32'(irq0), 32'h1);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("async_irq", 32'(irq0), 32'h0);
    check("async_out_port", 32'(out_port0), 32'h5A3);
    check("async_out_en", 32'(out_en0), 32'h0);
    rd0(3'd6, d); check("rst_addr6", d, 32'h0);
    rd0(3'd3, d); check("rst_edgecap", d, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    rd0(3'd3, d); check("post_rst_warm", d, 32'h0);
    check("post_rst_irq", 32'(irq0), 32'h0);
    check("post_rst_out_port", 32'(out_port0), 32'h5A3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
